// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - fixed-priority interrupt scheduler for the fetch unit
// Optional preemption of lower-priority service routines: INT_NESTING_EN
module int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic       hazard,
  input  logic       data_hazard,
  input  logic       branch_hazard,
  input  logic       pipeline_flush,
  input  logic       p_cache_miss,
  input  logic       CALL2,
  input  logic       RET,
  input  logic       reg_wr,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic [7:0] reg_dout,
  output logic       interrupt,
  output logic [2:0] int_addr,
  output logic       int_active
);

  typedef enum logic [1:0] {IDLE, WAIT_SAFE, ISSUE, IN_SERVICE} state_t;

  state_t     state, state_nxt;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] irq_prev, rise;
  logic [7:0] mask, pend, pend_nxt, isr, isr_nxt;
  logic [7:0] req, elig, prio_mask;
  logic       gie, clean, ret_t, track;
  logic [3:0] cnt, depth, depth_nxt;
  logic [2:0] cur, win;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest = 3'(i);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      irq_prev <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      irq_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = sync_q[SYNC_STAGES-1] & ~irq_prev;
  assign clean = ~(hazard | data_hazard | branch_hazard | pipeline_flush | p_cache_miss);
  assign ret_t = RET & ~branch_hazard & ~CALL2;
  assign req   = pend & mask;
  assign cur   = lowest(isr);
  // Only levels above the one in service may compete; with nothing in service all may.
  assign prio_mask = (isr == 8'd0) ? 8'hFF : ((8'h01 << cur) - 8'h01);
  assign elig  = req & prio_mask;
  assign win   = lowest(elig);
  assign track = (state != ISSUE) && (isr != 8'd0);

`ifdef INT_NESTING_EN
  logic [3:0] depth_save [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) depth_save[i] <= '0;
    end else if (state == ISSUE && isr != 8'd0) begin
      depth_save[cur] <= depth;
    end
  end
`endif

  always_comb begin
    isr_nxt   = isr;
    depth_nxt = depth;
    if (state == ISSUE) begin
      isr_nxt[int_addr] = 1'b1;
      depth_nxt         = 4'd0;
    end else if (track) begin
      if (CALL2) begin
        depth_nxt = (depth == 4'd15) ? 4'd15 : depth + 4'd1;
      end else if (ret_t) begin
        if (depth != 4'd0) begin
          depth_nxt = depth - 4'd1;
        end else begin
          isr_nxt[cur] = 1'b0;
`ifdef INT_NESTING_EN
          depth_nxt = (isr_nxt != 8'd0) ? depth_save[lowest(isr_nxt)] : 4'd0;
`endif
        end
      end
    end
  end

  // A fresh edge beats both the W1C write and the issue-time clear.
  always_comb begin
    pend_nxt = pend;
    if (state == ISSUE) pend_nxt[int_addr] = 1'b0;
    if (reg_wr && reg_addr == 2'd1) pend_nxt = pend_nxt & ~reg_din;
    pend_nxt = pend_nxt | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= '0;
      gie      <= 1'b0;
      pend     <= '0;
      isr      <= '0;
      depth    <= '0;
      cnt      <= '0;
      int_addr <= '0;
    end else begin
      if (reg_wr && reg_addr == 2'd0) mask <= reg_din;
      if (reg_wr && reg_addr == 2'd2) gie  <= reg_din[0];
      pend  <= pend_nxt;
      isr   <= isr_nxt;
      depth <= depth_nxt;
      if (state != WAIT_SAFE || !clean) cnt <= '0;
      else if (cnt != 4'(HOLDOFF))      cnt <= cnt + 4'd1;
      if (state == WAIT_SAFE && state_nxt == ISSUE) int_addr <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (gie && elig != 8'd0) state_nxt = WAIT_SAFE;
      WAIT_SAFE: begin
        if (!gie || elig == 8'd0)      state_nxt = (isr_nxt != 8'd0) ? IN_SERVICE : IDLE;
        else if (cnt == 4'(HOLDOFF))   state_nxt = ISSUE;
      end
      ISSUE:      state_nxt = IN_SERVICE;
      IN_SERVICE: begin
        if (isr_nxt == 8'd0) state_nxt = IDLE;
`ifdef INT_NESTING_EN
        else if (gie && elig != 8'd0) state_nxt = WAIT_SAFE;
`endif
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    interrupt  = (state == ISSUE);
    int_active = (isr != 8'd0);
    case (reg_addr)
      2'd0:    reg_dout = mask;
      2'd1:    reg_dout = pend;
      2'd2:    reg_dout = {7'd0, gie};
      default: reg_dout = isr;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       rst, hazard, data_hazard, branch_hazard, pipeline_flush, p_cache_miss;
  logic       CALL2, RET, reg_wr;
  logic [7:0] irq, reg_din, reg_dout;
  logic [1:0] reg_addr;
  logic       interrupt, int_active;
  logic [2:0] int_addr;

  int checks = 0;
  int failures = 0;

  logic [7:0] d;
  bit         found;
  int         cyc;
  logic [2:0] addr;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .hazard(hazard), .data_hazard(data_hazard),
    .branch_hazard(branch_hazard), .pipeline_flush(pipeline_flush),
    .p_cache_miss(p_cache_miss), .CALL2(CALL2), .RET(RET), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout),
    .interrupt(interrupt), .int_addr(int_addr), .int_active(int_active)
  );

  task tick;
    @(posedge clk);
    #2;
  endtask

  task reg_write(input logic [1:0] a, input logic [7:0] v);
    reg_wr = 1'b1; reg_addr = a; reg_din = v;
    tick();
    reg_wr = 1'b0; reg_din = 8'd0;
  endtask

  task rd(input logic [1:0] a, output logic [7:0] v);
    reg_addr = a;
    #1;
    v = reg_dout;
  endtask

  task automatic wait_int(input int max_cyc, output bit f, output int c, output logic [2:0] a);
    f = 1'b0; c = max_cyc; a = 3'd0;
    for (int i = 1; i <= max_cyc && !f; i++) begin
      tick();
      if (interrupt === 1'b1) begin
        f = 1'b1; c = i; a = int_addr;
      end
    end
  endtask

  task settle;
    irq = 8'd0;
    repeat (4) tick();
  endtask

  task test_reset;
    rst = 1'b1; irq = 8'd0; hazard = 0; data_hazard = 0; branch_hazard = 0;
    pipeline_flush = 0; p_cache_miss = 0; CALL2 = 0; RET = 0;
    reg_wr = 0; reg_addr = 2'd0; reg_din = 8'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_interrupt: got %b expected 0", interrupt); end
    checks++;
    if (int_addr !== 3'd0) begin failures++; $display("FAIL reset_int_addr: got %0d expected 0", int_addr); end
    checks++;
    if (int_active !== 1'b0) begin failures++; $display("FAIL reset_int_active: got %b expected 0", int_active); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL reset_reg%0d: got %h expected 00", a, d); end
    end
  endtask

  task test_single;
    reg_write(2'd2, 8'hFF);
    rd(2'd2, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL ctrl_readback: got %h expected 01", d); end
    reg_write(2'd0, 8'h08);
    rd(2'd0, d);
    checks++;
    if (d !== 8'h08) begin failures++; $display("FAIL mask_readback: got %h expected 08", d); end
    irq = 8'h08;
    wait_int(20, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd3) begin failures++; $display("FAIL single_addr: found=%b got %0d expected 3", found, addr); end
    checks++;
    if (cyc !== 8) begin failures++; $display("FAIL single_latency: got %0d expected 8", cyc); end
    tick();
    checks++;
    if (interrupt !== 1'b0) begin failures++; $display("FAIL single_pulse_width: got %b expected 0", interrupt); end
    rd(2'd3, d);
    checks++;
    if (d !== 8'h08) begin failures++; $display("FAIL single_isr: got %h expected 08", d); end
    rd(2'd1, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL single_pend: got %h expected 00", d); end
    checks++;
    if (int_active !== 1'b1) begin failures++; $display("FAIL single_active: got %b expected 1", int_active); end
    RET = 1'b1; tick(); RET = 1'b0;
    checks++;
    if (int_active !== 1'b0) begin failures++; $display("FAIL single_exit: got %b expected 0", int_active); end
    settle();
  endtask

  task test_priority;
    reg_write(2'd0, 8'hFF);
    irq = 8'h24;
    wait_int(20, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd2) begin failures++; $display("FAIL prio_first: found=%b got %0d expected 2", found, addr); end
    tick();
    rd(2'd1, d);
    checks++;
    if (d !== 8'h20) begin failures++; $display("FAIL prio_pend: got %h expected 20", d); end
    RET = 1'b1; tick(); RET = 1'b0;
    wait_int(20, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd5) begin failures++; $display("FAIL prio_second: found=%b got %0d expected 5", found, addr); end
    tick();
    RET = 1'b1; tick(); RET = 1'b0;
    checks++;
    if (int_active !== 1'b0) begin failures++; $display("FAIL prio_exit: got %b expected 0", int_active); end
    settle();
  endtask

  task test_holdoff;
    int pulses;
    pulses = 0;
    reg_write(2'd0, 8'h01);
    irq = 8'h01;
    for (int i = 0; i < 24; i++) begin
      branch_hazard = ((i >> 1) & 1) != 0;
      tick();
      if (interrupt === 1'b1) pulses++;
    end
    branch_hazard = 1'b1;
    tick();
    if (interrupt === 1'b1) pulses++;
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL holdoff_blocked: got %0d pulses expected 0", pulses); end
    branch_hazard = 1'b0;
    wait_int(10, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd0) begin failures++; $display("FAIL holdoff_addr: found=%b got %0d expected 0", found, addr); end
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL holdoff_latency: got %0d expected 4", cyc); end
    tick();
    RET = 1'b1; tick(); RET = 1'b0;
    settle();
  endtask

  task test_depth;
    reg_write(2'd0, 8'h40);
    irq = 8'h40;
    wait_int(20, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd6) begin failures++; $display("FAIL depth_issue: found=%b got %0d expected 6", found, addr); end
    tick();
    CALL2 = 1'b1; tick(); tick(); CALL2 = 1'b0;
    RET = 1'b1; tick(); tick(); RET = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 8'h40) begin failures++; $display("FAIL depth_after_two_ret: got %h expected 40", d); end
    RET = 1'b1; branch_hazard = 1'b1; tick(); RET = 1'b0; branch_hazard = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 8'h40) begin failures++; $display("FAIL depth_ret_hazard: got %h expected 40", d); end
    RET = 1'b1; tick(); RET = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL depth_third_ret: got %h expected 00", d); end
    checks++;
    if (int_active !== 1'b0) begin failures++; $display("FAIL depth_active: got %b expected 0", int_active); end
    settle();
  endtask

  task test_w1c_race;
    reg_write(2'd0, 8'h00);
    irq = 8'h10;
    tick(); tick();
    reg_wr = 1'b1; reg_addr = 2'd1; reg_din = 8'h10;
    tick();
    reg_wr = 1'b0; reg_din = 8'd0;
    rd(2'd1, d);
    checks++;
    if (d !== 8'h10) begin failures++; $display("FAIL w1c_race: got %h expected 10", d); end
    reg_write(2'd1, 8'h10);
    rd(2'd1, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL w1c_clear: got %h expected 00", d); end
    settle();
  endtask

`ifdef INT_NESTING_EN
  task test_nesting;
    reg_write(2'd0, 8'hFF);
    irq = 8'h20;
    wait_int(20, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd5) begin failures++; $display("FAIL nest_outer: found=%b got %0d expected 5", found, addr); end
    tick();
    CALL2 = 1'b1; tick(); tick(); CALL2 = 1'b0;
    irq = 8'h22;
    wait_int(20, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd1) begin failures++; $display("FAIL nest_preempt: found=%b got %0d expected 1", found, addr); end
    tick();
    rd(2'd3, d);
    checks++;
    if (d !== 8'h22) begin failures++; $display("FAIL nest_isr_both: got %h expected 22", d); end
    RET = 1'b1; tick(); RET = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 8'h20) begin failures++; $display("FAIL nest_inner_exit: got %h expected 20", d); end
    RET = 1'b1; tick(); tick(); RET = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 8'h20) begin failures++; $display("FAIL nest_depth_restored: got %h expected 20", d); end
    RET = 1'b1; tick(); RET = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL nest_outer_exit: got %h expected 00", d); end
    settle();
  endtask
`endif

  task test_reset_mid_isr;
    reg_write(2'd0, 8'h02);
    irq = 8'h02;
    wait_int(20, found, cyc, addr);
    checks++;
    if (!found || addr !== 3'd1) begin failures++; $display("FAIL rst_issue: found=%b got %0d expected 1", found, addr); end
    tick();
    CALL2 = 1'b1; tick(); CALL2 = 1'b0;
    rst = 1'b1; irq = 8'd0;
    tick();
    checks++;
    if (interrupt !== 1'b0 || int_active !== 1'b0 || int_addr !== 3'd0) begin
      failures++;
      $display("FAIL rst_outputs: got int=%b act=%b addr=%0d expected 0 0 0", interrupt, int_active, int_addr);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL rst_reg%0d: got %h expected 00", a, d); end
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_holdoff();
    test_depth();
    test_w1c_race();
`ifdef INT_NESTING_EN
    test_nesting();
`endif
    test_reset_mid_isr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
